// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: routes note events to a bank of note players,
// picking the lowest free voice or stealing the least-recently-loaded one.

module voice_slot #(
  parameter int AW  = 2,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          load_any,
  input  logic          done,
  input  logic [AW-1:0] tgt_age,
  output logic          busy,
  output logic          busy_next,
  output logic [AW-1:0] age
);
  // A reload on the same cycle as the old note's done keeps the voice busy.
  assign busy_next = load | (busy & ~done);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      age  <= AW'(IDX);
    end else begin
      busy <= busy_next;
      if (load_any) begin
        if (load)                age <= '0;
        else if (age < tgt_age)  age <= age + AW'(1);
      end
    end
  end
endmodule

module voice_allocator #(
  parameter int NUM_VOICES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic [5:0]            note_in,
  input  logic [5:0]            duration_in,
  input  logic                  note_valid,
  output logic                  note_ready,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [5:0]            voice_note,
  output logic [5:0]            voice_duration,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  steal,
  output logic [3:0]            active_count
);
  localparam int AW = $clog2(NUM_VOICES);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                         state;
  logic [AW-1:0]                  tgt, sel;
  logic                           sel_found;
  logic                           accept;
  logic [NUM_VOICES-1:0][AW-1:0]  age;
  logic [NUM_VOICES-1:0]          busy_next;

  assign note_ready = (state == IDLE) & play_enable & ~reset;
  assign accept     = note_valid & note_ready;

  function automatic logic [3:0] popcount(input logic [NUM_VOICES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_VOICES; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  // Lowest free voice wins; with none free, the oldest rank is stolen.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!voice_busy[i]) begin
        sel       = AW'(i);
        sel_found = 1'b1;
      end
    end
    if (!sel_found) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (age[i] == AW'(NUM_VOICES - 1)) sel = AW'(i);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_VOICES; g++) begin : g_slot
      voice_slot #(.AW(AW), .IDX(g)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (voice_load[g]),
        .load_any  (state == LOAD),
        .done      (voice_done[g]),
        .tgt_age   (age[tgt]),
        .busy      (voice_busy[g]),
        .busy_next (busy_next[g]),
        .age       (age[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tgt            <= '0;
      voice_load     <= '0;
      voice_note     <= '0;
      voice_duration <= '0;
      steal          <= 1'b0;
      active_count   <= '0;
    end else begin
      active_count <= popcount(busy_next);
      case (state)
        IDLE: begin
          // Rests are consumed without touching any voice.
          if (accept && note_in != 6'd0) begin
            tgt            <= sel;
            voice_load     <= NUM_VOICES'(1) << sel;
            steal          <= voice_busy[sel];
            voice_note     <= note_in;
            voice_duration <= duration_in;
            state          <= LOAD;
          end
        end
        LOAD: begin
          voice_load <= '0;
          steal      <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, stealing, rests, enable and reset.

module tb_voice_allocator;
  logic       clk = 1'b0;
  logic       reset;
  logic       play_enable;
  logic [5:0] note_in, duration_in;
  logic       note_valid;
  logic       note_ready;
  logic [2:0] voice_done, voice_load, voice_busy;
  logic [5:0] voice_note, voice_duration;
  logic       steal;
  logic [3:0] active_count;

  int errors = 0;
  int checks = 0;

  voice_allocator #(.NUM_VOICES(3)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable),
    .note_in(note_in), .duration_in(duration_in), .note_valid(note_valid),
    .note_ready(note_ready), .voice_done(voice_done), .voice_load(voice_load),
    .voice_note(voice_note), .voice_duration(voice_duration),
    .voice_busy(voice_busy), .steal(steal), .active_count(active_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one note, check the LOAD cycle, then return to IDLE.
  task automatic send(input logic [5:0] n, input logic [5:0] d, input logic [2:0] exp_load,
                      input logic exp_steal, input logic [2:0] exp_busy, input int exp_cnt);
    note_in = n; duration_in = d; note_valid = 1'b1;
    #1 chk("ready_idle", note_ready, 1);
    tick;
    chk("load",      voice_load, exp_load);
    chk("note",      voice_note, n);
    chk("dur",       voice_duration, d);
    chk("steal",     steal, exp_steal);
    chk("ready_ld",  note_ready, 0);
    note_valid = 1'b0;
    tick;
    chk("load_off",  voice_load, 0);
    chk("steal_off", steal, 0);
    chk("busy",      voice_busy, exp_busy);
    chk("count",     active_count, exp_cnt);
  endtask

  initial begin
    reset = 1'b1; play_enable = 1'b1; note_valid = 1'b0;
    note_in = '0; duration_in = '0; voice_done = '0;

    // Reset held three cycles
    repeat (3) begin
      tick;
      chk("rst_ready", note_ready, 0);
      chk("rst_load",  voice_load, 0);
      chk("rst_busy",  voice_busy, 0);
      chk("rst_cnt",   active_count, 0);
      chk("rst_note",  voice_note, 0);
      chk("rst_steal", steal, 0);
    end
    reset = 1'b0;
    #1 chk("ready_after_rst", note_ready, 1);

    // Fill all voices in order
    send(6'd20, 6'd8, 3'b001, 0, 3'b001, 1);
    send(6'd24, 6'd8, 3'b010, 0, 3'b011, 2);
    send(6'd27, 6'd8, 3'b100, 0, 3'b111, 3);

    // Steal the oldest (ranks v0=2,v1=1,v2=0), then next oldest
    send(6'd30, 6'd5, 3'b001, 1, 3'b111, 3);
    send(6'd31, 6'd5, 3'b010, 1, 3'b111, 3);

    // Free voice 1, then it is the lowest free voice
    voice_done = 3'b010;
    tick;
    voice_done = 3'b000;
    chk("done_busy", voice_busy, 3'b101);
    chk("done_cnt",  active_count, 2);
    send(6'd15, 6'd3, 3'b010, 0, 3'b111, 3);
    // Ranks now v0=1,v1=0,v2=2
    send(6'd40, 6'd2, 3'b100, 1, 3'b111, 3);

    // Done during reload of the same voice: set wins (v0 is oldest)
    note_in = 6'd41; duration_in = 6'd1; note_valid = 1'b1;
    tick;
    chk("reld_load", voice_load, 3'b001);
    chk("reld_steal", steal, 1);
    note_valid = 1'b0; voice_done = 3'b001;
    tick;
    voice_done = 3'b000;
    chk("reld_busy", voice_busy, 3'b111);
    chk("reld_cnt",  active_count, 3);

    // Rest is consumed with no load
    note_in = 6'd0; duration_in = 6'd4; note_valid = 1'b1;
    #1 chk("rest_ready0", note_ready, 1);
    tick;
    note_valid = 1'b0;
    chk("rest_load",  voice_load, 0);
    chk("rest_ready", note_ready, 1);
    chk("rest_hold",  voice_note, 41);

    // play_enable low blocks acceptance
    play_enable = 1'b0; note_in = 6'd22; duration_in = 6'd6; note_valid = 1'b1;
    #1 chk("dis_ready", note_ready, 0);
    repeat (2) begin
      tick;
      chk("dis_load", voice_load, 0);
    end
    play_enable = 1'b1;
    // Ranks v0=0,v1=2,v2=1 -> v1 stolen
    send(6'd22, 6'd6, 3'b010, 1, 3'b111, 3);

    // Reset mid-LOAD: strobe cut short, state cleared
    note_in = 6'd50; duration_in = 6'd7; note_valid = 1'b1;
    tick;
    chk("pre_rst_load", voice_load, 3'b100);
    reset = 1'b1; note_valid = 1'b0;
    tick;
    chk("mid_rst_load", voice_load, 0);
    chk("mid_rst_busy", voice_busy, 0);
    chk("mid_rst_cnt",  active_count, 0);
    reset = 1'b0;
    tick;
    chk("post_rst_load", voice_load, 0);
    chk("post_rst_busy", voice_busy, 0);

    // Done on idle voices ignored
    voice_done = 3'b111;
    tick;
    voice_done = 3'b000;
    chk("idle_done_busy", voice_busy, 0);

    // Ranks back to 0,1,2: fill, then voice 0 is stolen first
    send(6'd1, 6'd1, 3'b001, 0, 3'b001, 1);
    send(6'd2, 6'd1, 3'b010, 0, 3'b011, 2);
    send(6'd3, 6'd1, 3'b100, 0, 3'b111, 3);
    send(6'd4, 6'd1, 3'b001, 1, 3'b111, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
